vend_ctrl_param: RTL and testbench
==================================

// Module: vend_ctrl_param
// PURPOSE
//  Parametrised vending-machine controller, next generation of the keypad-driven vend FSM.
//  Consumes debounced keypad strobes and runs select -> quantity -> confirm -> pay -> vend -> change.
//  Prices come from an N_PROD-entry table; credit is accumulated from coin keys.
//  Dispensing is a valid/ready handshake to the motor driver. State and display values feed the BCD/7-seg path.
// PARAMETERS
//  N_PROD   5  number of products, 1..7; keys 1..N_PROD select product 0..N_PROD-1
//  PRICE_W  8  price width in currency units
//  QTY_W    2  quantity width; legal quantity 1..2^QTY_W-1
//  TOT_W    PRICE_W+QTY_W  (localparam) width of total, credit, change
//  TIMEOUT_CYC 1000  idle-abort cycles (used only with VEND_TIMEOUT_EN)
// PORTS
//  clk          in   1                 system clock
//  reset        in   1                 synchronous, active-high reset
//  key_valid    in   1                 one-cycle strobe per debounced key press
//  key_code     in   4                 key value, sampled only when key_valid=1
//  price_table  in   N_PROD*PRICE_W    product i price at [i*PRICE_W +: PRICE_W]
//  stock_empty  in   N_PROD            product i sold out when bit i=1
//  vend_valid   out  1                 dispense request, held until accepted
//  vend_ready   in   1                 dispenser accepts when vend_valid&vend_ready
//  vend_id      out  3                 product index for dispense
//  vend_qty     out  QTY_W             quantity for dispense
//  change_valid out  1                 one-cycle pulse: change_amt is valid
//  change_amt   out  TOT_W             change or refund amount
//  state_code   out  3                 current state encoding, for display
//  disp_value   out  TOT_W             value to display (see BEHAVIOUR)
// BEHAVIOUR
//  Keys: 1..N_PROD = product; 8/9/A = coin 1/5/10; F = OK; E = confirm; C = cancel; others ignored.
//  States: IDLE=0 SEL=1 QTY=2 CONF=3 PAY=4 VEND=5 CHG=6. All transitions are registered.
//   Each transition occurs on the edge after the qualifying key_valid.
//  IDLE: F -> SEL.
//  SEL: key k in 1..N_PROD with stock_empty[k-1]=0 latches id=k-1 and qty=1 -> QTY.
//   Sold-out or out-of-range keys are ignored.
//  QTY: keys 1..2^QTY_W-1 overwrite qty; 0 and larger values are ignored; F -> CONF.
//  CONF: total = price[id]*qty (unsigned, TOT_W, no overflow by construction) is registered.
//   E -> PAY with credit=0.
//  PAY: coin key adds its value to credit.
//   Credit saturates at 2^TOT_W-1.
//   Once credit>=total -> VEND; any coin key on that same edge is ignored.
//  VEND: vend_valid=1; vend_id and vend_qty stay stable while waiting.
//   On vend_valid&vend_ready, vend_valid drops next cycle -> CHG.
//  CHG: change_valid=1 for exactly one cycle with change_amt=credit-total.
//   Pulse fires even when the value is 0, then -> IDLE.
//  Cancel (C) in SEL/QTY/CONF -> IDLE, with no change pulse.
//  Cancel (C) in PAY -> CHG with change_amt=credit (full refund), then IDLE.
//  Cancel is ignored in IDLE/VEND/CHG.
//  disp_value: IDLE 0; SEL last key code; QTY qty; CONF total; PAY credit; VEND total; CHG change_amt.
//  Reset (any state, incl. mid-VEND): state=IDLE, and every output is 0 the next cycle.
//   Latched id/qty/total/credit are cleared; any pending vend is dropped.
//  stock_empty changing after selection has no effect on the current transaction.
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: idle counter runs in SEL/QTY/CONF/PAY, cleared on each key_valid.
//   On reaching TIMEOUT_CYC it acts as cancel: PAY refunds credit via CHG; others -> IDLE.
//  Undefined: no counter; the FSM waits indefinitely in every state.
// TESTING
//  Defaults, prices {6,10,5,2,1}: F,2,F,E,A -> vend_valid id=1 qty=1; ready -> change pulse 0.
//  F,1,3,F,E,A,9,8 -> total 18; credit 10,15,16 no vend; A -> credit 26, vend qty 3, change 8.
//  stock_empty=5'b00010: F,2 stays SEL; 3 -> QTY id=2.
//  PAY with credit 15, key C -> change_valid one cycle, amt 15, state IDLE, no vend_valid.
//  vend_ready low 20 cycles -> vend_valid/id stable; reset mid-VEND -> all outputs 0, IDLE.
//  VEND_TIMEOUT_EN, TIMEOUT_CYC=16: PAY credit 5, no key 16 cycles -> refund 5, IDLE.

Source files
------------

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: keypad-driven vending controller.
// Flow: select -> quantity -> confirm -> pay -> vend -> change, with a
// valid/ready handshake to the dispenser and a one-cycle change pulse.
// Optional feature macro: VEND_TIMEOUT_EN (idle abort after TIMEOUT_CYC cycles).
module vend_ctrl_param #(
    parameter int N_PROD      = 5,
    parameter int PRICE_W     = 8,
    parameter int QTY_W       = 2,
    parameter int TIMEOUT_CYC = 1000,
    localparam int TOT_W      = PRICE_W + QTY_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    input  logic [N_PROD*PRICE_W-1:0] price_table,
    input  logic [N_PROD-1:0]         stock_empty,
    output logic                      vend_valid,
    input  logic                      vend_ready,
    output logic [2:0]                vend_id,
    output logic [QTY_W-1:0]          vend_qty,
    output logic                      change_valid,
    output logic [TOT_W-1:0]          change_amt,
    output logic [2:0]                state_code,
    output logic [TOT_W-1:0]          disp_value
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEL  = 3'd1;
    localparam logic [2:0] S_QTY  = 3'd2;
    localparam logic [2:0] S_CONF = 3'd3;
    localparam logic [2:0] S_PAY  = 3'd4;
    localparam logic [2:0] S_VEND = 3'd5;
    localparam logic [2:0] S_CHG  = 3'd6;

    localparam logic [3:0] K_OK     = 4'hF;
    localparam logic [3:0] K_CONF   = 4'hE;
    localparam logic [3:0] K_CANCEL = 4'hC;
    localparam logic [3:0] NP_K     = 4'(N_PROD);
    localparam logic [3:0] QMAX_K   = 4'((1 << QTY_W) - 1);

    logic [2:0]         state;
    logic [2:0]         id;
    logic [QTY_W-1:0]   qty;
    logic [TOT_W-1:0]   total;
    logic [TOT_W-1:0]   credit;
    logic [TOT_W-1:0]   chg;
    logic [3:0]         last_key;

    logic               is_prod;
    logic [2:0]         prod_idx;
    logic               is_coin;
    logic [3:0]         coin_val;
    logic [TOT_W:0]     credit_sum;
    logic [TOT_W-1:0]   credit_sat;
    logic [PRICE_W-1:0] price_sel;
    logic               cancel;
    logic               to_fire;

    assign is_prod    = (key_code >= 4'd1) && (key_code <= NP_K);
    assign prod_idx   = 3'(key_code - 4'd1);
    assign price_sel  = price_table[int'(id)*PRICE_W +: PRICE_W];
    assign cancel     = key_valid && (key_code == K_CANCEL);
    assign credit_sum = {1'b0, credit} + (TOT_W+1)'(coin_val);
    assign credit_sat = credit_sum[TOT_W] ? '1 : credit_sum[TOT_W-1:0];

    // Coin key decode: 8/9/A are worth 1/5/10 units
    always_comb begin
        is_coin  = 1'b0;
        coin_val = 4'd0;
        case (key_code)
            4'h8:    begin is_coin = 1'b1; coin_val = 4'd1;  end
            4'h9:    begin is_coin = 1'b1; coin_val = 4'd5;  end
            4'hA:    begin is_coin = 1'b1; coin_val = 4'd10; end
            default: ;
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            waiting;

    assign waiting = (state == S_SEL) || (state == S_QTY) ||
                     (state == S_CONF) || (state == S_PAY);
    assign to_fire = waiting && !key_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Idle counter: restarts on any key press or outside the waiting states
    always_ff @(posedge clk) begin
        if (reset || !waiting || key_valid) to_cnt <= '0;
        else if (!to_fire)                  to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_fire = 1'b0;
`endif

    // Main transaction FSM and its latched id/qty/total/credit/change
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            id       <= '0;
            qty      <= '0;
            total    <= '0;
            credit   <= '0;
            chg      <= '0;
            last_key <= '0;
        end else begin
            if (key_valid) last_key <= key_code;
            case (state)
                S_IDLE: if (key_valid && key_code == K_OK) state <= S_SEL;
                S_SEL: begin
                    if (cancel || to_fire) state <= S_IDLE;
                    else if (key_valid && is_prod && !stock_empty[prod_idx]) begin
                        id    <= prod_idx;
                        qty   <= QTY_W'(1);
                        state <= S_QTY;
                    end
                end
                S_QTY: begin
                    if (cancel || to_fire) state <= S_IDLE;
                    else if (key_valid && key_code == K_OK) begin
                        // price[id]*qty always fits TOT_W
                        total <= TOT_W'(price_sel) * TOT_W'(qty);
                        state <= S_CONF;
                    end else if (key_valid && key_code >= 4'd1 && key_code <= QMAX_K)
                        qty <= QTY_W'(key_code);
                end
                S_CONF: begin
                    if (cancel || to_fire) state <= S_IDLE;
                    else if (key_valid && key_code == K_CONF) begin
                        credit <= '0;
                        state  <= S_PAY;
                    end
                end
                S_PAY: begin
                    // Paid-up check wins over a coin or cancel arriving the same edge
                    if (credit >= total) state <= S_VEND;
                    else if (cancel || to_fire) begin
                        chg   <= credit;
                        state <= S_CHG;
                    end else if (key_valid && is_coin)
                        credit <= credit_sat;
                end
                S_VEND: begin
                    if (vend_ready) begin
                        chg   <= credit - total;
                        state <= S_CHG;
                    end
                end
                S_CHG:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign vend_valid   = (state == S_VEND);
    assign vend_id      = id;
    assign vend_qty     = qty;
    assign change_valid = (state == S_CHG);
    assign change_amt   = chg;
    assign state_code   = state;

    // Display mux follows the current state
    always_comb begin
        disp_value = '0;
        case (state)
            S_SEL:  disp_value = TOT_W'(last_key);
            S_QTY:  disp_value = TOT_W'(qty);
            S_CONF: disp_value = total;
            S_PAY:  disp_value = credit;
            S_VEND: disp_value = total;
            S_CHG:  disp_value = chg;
            default: disp_value = '0;
        endcase
    end
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param (default build, prices {6,10,5,2,1}).
module tb_vend_ctrl_param;
    localparam int N_PROD  = 5;
    localparam int PRICE_W = 8;
    localparam int QTY_W   = 2;
    localparam int TOT_W   = PRICE_W + QTY_W;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      key_valid;
    logic [3:0]                key_code;
    logic [N_PROD*PRICE_W-1:0] price_table;
    logic [N_PROD-1:0]         stock_empty;
    logic                      vend_valid;
    logic                      vend_ready;
    logic [2:0]                vend_id;
    logic [QTY_W-1:0]          vend_qty;
    logic                      change_valid;
    logic [TOT_W-1:0]          change_amt;
    logic [2:0]                state_code;
    logic [TOT_W-1:0]          disp_value;

    int n_chk  = 0;
    int n_fail = 0;
    logic [4:0]       vq[$];   // expected {id, qty} per dispense handshake
    logic [TOT_W-1:0] cq[$];   // expected change per change pulse

    vend_ctrl_param #(.N_PROD(N_PROD), .PRICE_W(PRICE_W), .QTY_W(QTY_W)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .price_table(price_table), .stock_empty(stock_empty),
        .vend_valid(vend_valid), .vend_ready(vend_ready), .vend_id(vend_id),
        .vend_qty(vend_qty), .change_valid(change_valid), .change_amt(change_amt),
        .state_code(state_code), .disp_value(disp_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic key(input logic [3:0] k);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic accept();
        @(posedge clk); #1;
        vend_ready = 1'b1;
        @(posedge clk); #1;
        vend_ready = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake and every change pulse
    initial begin
        logic [4:0]       ev;
        logic [TOT_W-1:0] ec;
        forever begin
            @(negedge clk);
            if (vend_valid && vend_ready) begin
                if (vq.size() == 0) chk("unexpected_vend", 32'(vend_id), 32'hFFFF);
                else begin
                    ev = vq.pop_front();
                    chk("vend_id", 32'(vend_id), 32'(ev[4:2]));
                    chk("vend_qty", 32'(vend_qty), 32'(ev[1:0]));
                end
            end
            if (change_valid) begin
                if (cq.size() == 0) chk("unexpected_change", 32'(change_amt), 32'hFFFF);
                else begin
                    ec = cq.pop_front();
                    chk("change_amt", 32'(change_amt), 32'(ec));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; vend_ready = 1'b0;
        stock_empty = '0;
        price_table = {8'd1, 8'd2, 8'd5, 8'd10, 8'd6};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_state", 32'(state_code), 0);
        chk("rst_vend_valid", 32'(vend_valid), 0);
        chk("rst_change_valid", 32'(change_valid), 0);
        chk("rst_disp", 32'(disp_value), 0);

        // Cancel in IDLE is ignored
        key(4'hC); chk("idle_cancel", 32'(state_code), 0);

        // Basic vend: product 2 (price 10), pay 10, change 0
        key(4'hF); chk("t1_sel", 32'(state_code), 1);
        key(4'h6); chk("t1_oor_key", 32'(state_code), 1);
        key(4'h2); chk("t1_qty", 32'(state_code), 2); chk("t1_qty_disp", 32'(disp_value), 1);
        key(4'hF); chk("t1_conf", 32'(state_code), 3); chk("t1_total", 32'(disp_value), 10);
        key(4'hE); chk("t1_pay", 32'(state_code), 4); chk("t1_credit0", 32'(disp_value), 0);
        key(4'hA); chk("t1_pay_10", 32'(state_code), 4); chk("t1_credit10", 32'(disp_value), 10);
        step();    chk("t1_vend", 32'(state_code), 5); chk("t1_vend_valid", 32'(vend_valid), 1);
        vq.push_back({3'd1, 2'd1}); cq.push_back(10'd0);
        accept();  chk("t1_chg", 32'(state_code), 6);
        step();    chk("t1_idle", 32'(state_code), 0);

        // Quantity 3 of product 1 (6 each): ignore qty keys 0 and 4
        key(4'hF); key(4'h1);
        key(4'h0); chk("t2_qty0_ign", 32'(disp_value), 1);
        key(4'h4); chk("t2_qty4_ign", 32'(disp_value), 1);
        key(4'h3); chk("t2_qty3", 32'(disp_value), 3);
        key(4'hF); chk("t2_total", 32'(disp_value), 18);
        key(4'hE);
        key(4'hA); chk("t2_cr10", 32'(disp_value), 10);
        key(4'h9); chk("t2_cr15", 32'(disp_value), 15);
        key(4'h8); chk("t2_cr16", 32'(disp_value), 16); chk("t2_still_pay", 32'(state_code), 4);
        key(4'hA); chk("t2_cr26", 32'(disp_value), 26);
        step();    chk("t2_vend", 32'(state_code), 5); chk("t2_vend_disp", 32'(disp_value), 18);
        vq.push_back({3'd0, 2'd3}); cq.push_back(10'd8);
        accept(); step(); chk("t2_idle", 32'(state_code), 0);

        // Sold-out product 2 ignored; stock change after selection has no effect
        stock_empty = 5'b00010;
        key(4'hF); key(4'h2); chk("t3_soldout", 32'(state_code), 1); chk("t3_lastkey", 32'(disp_value), 2);
        key(4'h3); chk("t3_qty", 32'(state_code), 2);
        stock_empty = 5'b11111;
        key(4'hF); chk("t3_total", 32'(disp_value), 5);
        key(4'hE); key(4'hA);
        step();    chk("t3_vend_id", 32'(vend_id), 2);
        vq.push_back({3'd2, 2'd1}); cq.push_back(10'd5);
        accept(); step();
        stock_empty = '0;

        // Cancel in QTY: straight to IDLE, no change pulse
        key(4'hF); key(4'h1); key(4'hC); chk("t4_qty_cancel", 32'(state_code), 0);
        // Cancel in PAY with credit 15: full refund
        key(4'hF); key(4'h2); key(4'h2);
        key(4'hF); chk("t4_total", 32'(disp_value), 20);
        key(4'hE); key(4'hA); key(4'h9); chk("t4_cr15", 32'(disp_value), 15);
        cq.push_back(10'd15);
        key(4'hC); chk("t4_chg", 32'(state_code), 6); chk("t4_no_vend", 32'(vend_valid), 0);
        step();    chk("t4_idle", 32'(state_code), 0);

        // Dispenser stalls 20 cycles, then reset mid-VEND
        key(4'hF); key(4'h4); key(4'hF); key(4'hE); key(4'h8); key(4'h8);
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_hold", {29'd0, vend_valid, vend_id == 3'd3, vend_qty == 2'd1}, 32'd7);
        end
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_rst_state", 32'(state_code), 0);
        chk("t5_rst_outs", {27'd0, vend_valid, change_valid, |vend_id, |vend_qty, |change_amt}, 0);
        chk("t5_rst_disp", 32'(disp_value), 0);
        repeat (3) step();
        chk("t5_no_vend_after", 32'(vend_valid), 0);

        chk("vq_drained", 32'(vq.size()), 0);
        chk("cq_drained", 32'(cq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
